// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit adder built from a strict ripple chain of full-adder cells.
// Produces sum, carry-out and signed overflow one clock after a valid input.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] Sum,
   output logic             C_Out,
   output logic             ovf,
   output logic             out_valid
);
   logic [WIDTH:0]   carry_s;
   logic [WIDTH-1:0] sum_s;
   logic             ovf_s;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             valid_r;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry_s[i]),
         .s  (sum_s[i]),
         .co (carry_s[i+1])
      );
   end

   // For WIDTH = 1 the carry into the MSB is cin itself, which carry_s[0] already holds.
   assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];

   // Output register: capture on valid input, hold otherwise, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= in_valid;
         if (in_valid) begin
            sum_r  <= sum_s;
            cout_r <= carry_s[WIDTH];
            ovf_r  <= ovf_s;
         end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
         end
      end
   end

   assign Sum       = sum_r;
   assign C_Out     = cout_r;
   assign ovf       = ovf_r;
   assign out_valid = valid_r;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: WIDTH=1, 2 and 8 instances share one stimulus stream;
// a reference model pushes expected output state per cycle into per-width queues.

module tb_ripple_carry_adder;
   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      logic       vld;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       cin;
   logic [0:0] a1, b1, sum1;
   logic [1:0] a2, b2, sum2;
   logic [7:0] a8, b8, sum8;
   logic       co1, co2, co8, ov1, ov2, ov8, vo1, vo2, vo8;

   exp_t q1[$], q2[$], q8[$];
   exp_t prev1, prev2, prev8;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   ripple_carry_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
      .Sum(sum1), .C_Out(co1), .ovf(ov1), .out_valid(vo1));
   ripple_carry_adder #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a2), .b(b2), .cin(cin),
      .Sum(sum2), .C_Out(co2), .ovf(ov2), .out_valid(vo2));
   ripple_carry_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
      .Sum(sum8), .C_Out(co8), .ovf(ov8), .out_valid(vo8));

   // Reference: unsigned sum for Sum/C_Out, signed range check for ovf.
   function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic ci,
                                  logic rst, logic valid, exp_t prev);
      exp_t   e;
      longint mask, ua, ub, full, sa, sb, sres, smax, smin;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      full = ua + ub + longint'(ci);
      sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      sres = sa + sb + longint'(ci);
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      if (rst) begin
         e = '0;
      end else if (valid) begin
         e.sum  = 8'(full & mask);
         e.cout = ((full >> w) & 1) != 0;
         e.ovf  = (sres > smax) || (sres < smin);
         e.vld  = 1'b1;
      end else begin
         e     = prev;
         e.vld = 1'b0;
      end
      return e;
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare(string w, exp_t e, logic [7:0] s, logic co, logic ov, logic vo);
      check({w, ".Sum"}, s, e.sum);
      check({w, ".C_Out"}, {7'd0, co}, {7'd0, e.cout});
      check({w, ".ovf"}, {7'd0, ov}, {7'd0, e.ovf});
      check({w, ".out_valid"}, {7'd0, vo}, {7'd0, e.vld});
   endtask

   // One cycle: drive inputs, push expectations, clock, pop and compare.
   task automatic step(logic rst, logic valid, logic [7:0] a, logic [7:0] b, logic ci);
      exp_t e;
      rst_n    = ~rst;
      in_valid = valid;
      cin      = ci;
      a1 = a[0:0]; b1 = b[0:0];
      a2 = a[1:0]; b2 = b[1:0];
      a8 = a;      b8 = b;
      prev1 = model(1, a, b, ci, rst, valid, prev1); q1.push_back(prev1);
      prev2 = model(2, a, b, ci, rst, valid, prev2); q2.push_back(prev2);
      prev8 = model(8, a, b, ci, rst, valid, prev8); q8.push_back(prev8);
      @(posedge clk);
      #1;
      e = q1.pop_front(); compare("w1", e, {7'd0, sum1}, co1, ov1, vo1);
      e = q2.pop_front(); compare("w2", e, {6'd0, sum2}, co2, ov2, vo2);
      e = q8.pop_front(); compare("w8", e, sum8, co8, ov8, vo8);
   endtask

   initial begin
      prev1 = '0; prev2 = '0; prev8 = '0;
      // Reset overrides a valid input.
      step(1'b1, 1'b1, 8'h03, 8'h03, 1'b1);
      step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      // Directed WIDTH=2 cases.
      step(1'b0, 1'b1, 8'h01, 8'h03, 1'b1);
      step(1'b0, 1'b1, 8'h03, 8'h03, 1'b1);
      step(1'b0, 1'b1, 8'h02, 8'h01, 1'b0);
      step(1'b0, 1'b1, 8'h00, 8'h03, 1'b0);
      step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      step(1'b0, 1'b1, 8'h02, 8'h02, 1'b0);
      // Hold when not valid.
      step(1'b0, 1'b0, 8'h03, 8'h03, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      // Mid-stream reset, then recovery.
      step(1'b0, 1'b1, 8'h03, 8'h03, 1'b1);
      step(1'b1, 1'b1, 8'h03, 8'h03, 1'b0);
      step(1'b0, 1'b0, 8'h01, 8'h02, 1'b0);
      step(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
      // Full ripple on WIDTH=8 and other 8-bit corners.
      step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h7F, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      // Exhaustive 2-bit sweep, back-to-back.
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 8'(i & 3), 8'((i >> 2) & 3), i[4]);
      end
      // Random 8-bit traffic with gaps and occasional reset.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
